// File: rtl/la_wbm_pkg.sv
// +----------------------------------------------------------------------+
// | la_wbm_pkg : shared types and constants for the la_wb_master slice   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package la_wbm_pkg;

   localparam int c_addr_w          = 32;
   localparam int c_data_w          = 32;
   localparam int c_sel_w           = c_data_w / 8;
   localparam int c_timeout_default = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wbm_state_t;

endpackage

`default_nettype wire

// File: rtl/la_wb_master_if.sv
// +----------------------------------------------------------------------+
// | la_wb_master_if : command/response and Wishbone master signal bundle |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

interface la_wb_master_if;
   import la_wbm_pkg::*;

   logic                cmd_valid_i;
   logic                cmd_ready_o;
   logic                cmd_we_i;
   logic [c_sel_w-1:0]  cmd_sel_i;
   logic [c_addr_w-1:0] cmd_adr_i;
   logic [c_data_w-1:0] cmd_dat_i;

   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [c_data_w-1:0] rsp_dat_o;
   logic                rsp_err_o;

   logic                wbm_cyc_o;
   logic                wbm_stb_o;
   logic                wbm_we_o;
   logic [c_sel_w-1:0]  wbm_sel_o;
   logic [c_addr_w-1:0] wbm_adr_o;
   logic [c_data_w-1:0] wbm_dat_o;
   logic [c_data_w-1:0] wbm_dat_i;
   logic                wbm_ack_i;

   logic                busy_o;

   // Seen from the bridge itself
   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  rsp_ready_i,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i,
      output busy_o
   );

   // Seen from the command source / Wishbone slave side
   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_dat_o, rsp_err_o,
      output rsp_ready_i,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i,
      input  busy_o
   );

endinterface

`default_nettype wire

// File: rtl/la_wbm_timeout.sv
// +----------------------------------------------------------------------+
// | la_wbm_timeout : saturating BUS-cycle counter for the ack timeout    |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module la_wbm_timeout #(
   parameter int LIMIT = 255
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clear,
   input  wire logic enable,
   output logic      expired
);

   localparam int c_w = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [c_w-1:0] c_last = c_w'(LIMIT - 1);

   logic [c_w-1:0] r_count;

   // r_count holds the number of BUS cycles already completed, so the
   // LIMIT-th cycle is the one where it equals LIMIT-1.
   assign expired = enable && (r_count == c_last);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (enable && !expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/la_wb_master.sv
// +----------------------------------------------------------------------+
// | la_wb_master : single-outstanding command to Wishbone classic master |
// | Option LA_WBM_TIMEOUT_EN adds an ack timeout reported on rsp_err_o.  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module la_wb_master
   import la_wbm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = c_timeout_default
) (
   input  wire logic      wb_clk_i,
   input  wire logic      wb_rst_i,
   la_wb_master_if.master bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("la_wb_master: TIMEOUT_CYCLES must be at least 1");
   end

   wbm_state_t          r_state;
   wbm_state_t          w_next_state;
   logic                w_load;
   logic                r_cyc;
   logic                r_we;
   logic [c_sel_w-1:0]  r_sel;
   logic [c_addr_w-1:0] r_adr;
   logic [c_data_w-1:0] r_dat;
   logic [c_data_w-1:0] r_rsp_dat;
   logic [c_data_w-1:0] w_rsp_dat;

`ifdef LA_WBM_TIMEOUT_EN
   logic r_rsp_err;
   logic w_rsp_err;
   logic w_expired;

   la_wbm_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clear   (w_load),
      .enable  (r_state == ST_BUS),
      .expired (w_expired)
   );

   assign bus.rsp_err_o = r_rsp_err;
`else
   assign bus.rsp_err_o = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_rsp_dat    = r_rsp_dat;
`ifdef LA_WBM_TIMEOUT_EN
      w_rsp_err    = r_rsp_err;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.cmd_valid_i) begin
               w_next_state = ST_BUS;
               w_load       = 1'b1;
            end
         end
         ST_BUS: begin
            // Ack is tested first so it wins over a coinciding timeout
            if (bus.wbm_ack_i) begin
               w_next_state = ST_RESP;
               w_rsp_dat    = r_we ? '0 : bus.wbm_dat_i;
`ifdef LA_WBM_TIMEOUT_EN
               w_rsp_err    = 1'b0;
            end else if (w_expired) begin
               w_next_state = ST_RESP;
               w_rsp_dat    = '0;
               w_rsp_err    = 1'b1;
`endif
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready_i) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= ST_IDLE;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_rsp_dat <= '0;
`ifdef LA_WBM_TIMEOUT_EN
         r_rsp_err <= 1'b0;
`endif
      end else begin
         r_state   <= w_next_state;
         r_cyc     <= (w_next_state == ST_BUS);
         r_rsp_dat <= w_rsp_dat;
`ifdef LA_WBM_TIMEOUT_EN
         r_rsp_err <= w_rsp_err;
`endif
         if (w_load) begin
            r_we  <= bus.cmd_we_i;
            r_sel <= bus.cmd_sel_i;
            r_adr <= bus.cmd_adr_i;
            r_dat <= bus.cmd_dat_i;
         end
      end
   end

   assign bus.cmd_ready_o = (r_state == ST_IDLE);
   assign bus.rsp_valid_o = (r_state == ST_RESP);
   assign bus.rsp_dat_o   = r_rsp_dat;
   assign bus.busy_o      = (r_state != ST_IDLE);
   assign bus.wbm_cyc_o   = r_cyc;
   assign bus.wbm_stb_o   = r_cyc;
   assign bus.wbm_we_o    = r_we;
   assign bus.wbm_sel_o   = r_sel;
   assign bus.wbm_adr_o   = r_adr;
   assign bus.wbm_dat_o   = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_la_wb_master.sv
// +----------------------------------------------------------------------+
// | tb_la_wb_master : self-checking bench for la_wb_master               |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_la_wb_master;

`ifdef LA_WBM_TIMEOUT_EN
   localparam int TB_TMO = 4;
   localparam bit TMO_EN = 1'b1;
`else
   localparam int TB_TMO = 255;
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   la_wb_master_if bus ();

   la_wb_master #(
      .TIMEOUT_CYCLES (TB_TMO)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      int          ack_at;
      logic [31:0] rdata;
      int          hold;
      int          exp_cyc;
      logic [31:0] exp_dat;
      logic        exp_err;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Transaction-level reference: ack_at is the BUS cycle (1-based) that
   // carries the ack, 0 meaning the slave never acks.
   function automatic void model(input logic we, input int ack_at, input logic [31:0] rdata,
                                 output int cyc, output logic [31:0] dat, output logic err);
      bit timed_out;
      timed_out = TMO_EN && (ack_at == 0 || ack_at > TB_TMO);
      cyc = timed_out ? TB_TMO : ack_at;
      err = timed_out;
      dat = (timed_out || we) ? 32'h0 : rdata;
   endfunction

   task automatic run_txn(input string tag, input vec_t v);
      int cyc_cnt;
      @(negedge clk);
      chk({tag, " cmd_ready idle"}, {31'b0, bus.cmd_ready_o}, 32'd1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = v.we;
      bus.cmd_sel_i   = v.sel;
      bus.cmd_adr_i   = v.adr;
      bus.cmd_dat_i   = v.dat;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = ~v.we;
      bus.cmd_sel_i   = ~v.sel;
      bus.cmd_adr_i   = $urandom;
      bus.cmd_dat_i   = $urandom;
      cyc_cnt = 0;
      for (int k = 1; k <= 300; k++) begin
         if (!bus.wbm_cyc_o) break;
         cyc_cnt++;
         chk({tag, " wbm_adr"}, bus.wbm_adr_o, v.adr);
         chk({tag, " wbm_dat"}, bus.wbm_dat_o, v.dat);
         chk({tag, " stb/we/sel/cmd_ready/rsp_valid/busy"},
             {23'b0, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
              bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o},
             {23'b0, 1'b1, v.we, v.sel, 1'b0, 1'b0, 1'b1});
         bus.wbm_ack_i = (k == v.ack_at);
         bus.wbm_dat_i = (k == v.ack_at) ? v.rdata : $urandom;
         @(negedge clk);
      end
      bus.wbm_ack_i = 1'b0;
      chk({tag, " cyc cycles"}, 32'(cyc_cnt), 32'(v.exp_cyc));
      chk({tag, " rsp_valid"}, {31'b0, bus.rsp_valid_o}, 32'd1);
      chk({tag, " rsp_dat"}, bus.rsp_dat_o, v.exp_dat);
      chk({tag, " rsp_err"}, {31'b0, bus.rsp_err_o}, {31'b0, v.exp_err});
      for (int h = 0; h < v.hold; h++) begin
         bus.rsp_ready_i = 1'b0;
         bus.wbm_ack_i   = 1'b1;
         bus.wbm_dat_i   = $urandom;
         bus.cmd_valid_i = 1'b1;
         @(negedge clk);
         chk({tag, " hold rsp_dat"}, bus.rsp_dat_o, v.exp_dat);
         chk({tag, " hold valid/err/cmd_ready/cyc/stb"},
             {27'b0, bus.rsp_valid_o, bus.rsp_err_o, bus.cmd_ready_o, bus.wbm_cyc_o, bus.wbm_stb_o},
             {27'b0, 1'b1, v.exp_err, 1'b0, 1'b0, 1'b0});
      end
      bus.wbm_ack_i   = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      chk({tag, " after rsp valid/cmd_ready/busy/cyc"},
          {28'b0, bus.rsp_valid_o, bus.cmd_ready_o, bus.busy_o, bus.wbm_cyc_o},
          {28'b0, 1'b0, 1'b1, 1'b0, 1'b0});
   endtask

   function automatic vec_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] dat, input int ack_at, input logic [31:0] rdata,
                               input int hold);
      vec_t v;
      v.we = we; v.sel = sel; v.adr = adr; v.dat = dat;
      v.ack_at = ack_at; v.rdata = rdata; v.hold = hold;
      model(we, ack_at, rdata, v.exp_cyc, v.exp_dat, v.exp_err);
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before the bench completed");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_sel_i = '0;
      bus.cmd_adr_i = '0; bus.cmd_dat_i = '0; bus.rsp_ready_i = 1'b0;
      bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0;

      vecs[0] = '{we: 1'b1, sel: 4'hF, adr: 32'h3000_0004, dat: 32'hA5A5_1234, ack_at: 3,
                  rdata: 32'hDEAD_BEEF, hold: 0, exp_cyc: 3, exp_dat: 32'h0, exp_err: 1'b0};
      vecs[1] = '{we: 1'b0, sel: 4'hF, adr: 32'h3000_0000, dat: 32'h0, ack_at: 1,
                  rdata: 32'hCAFE_F00D, hold: 0, exp_cyc: 1, exp_dat: 32'hCAFE_F00D, exp_err: 1'b0};
      vecs[2] = '{we: 1'b0, sel: 4'h3, adr: 32'h1000_0010, dat: 32'h5555_AAAA, ack_at: 2,
                  rdata: 32'h1234_5678, hold: 5, exp_cyc: 2, exp_dat: 32'h1234_5678, exp_err: 1'b0};
      vecs[3] = '{we: 1'b1, sel: 4'h8, adr: 32'hFFFF_FFFC, dat: 32'h8000_0001, ack_at: 1,
                  rdata: 32'hFFFF_FFFF, hold: 1, exp_cyc: 1, exp_dat: 32'h0, exp_err: 1'b0};

      repeat (2) @(negedge clk);
      chk("reset cmd_ready/rsp_valid/rsp_err/cyc/stb/we/busy",
          {25'b0, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.wbm_cyc_o,
           bus.wbm_stb_o, bus.wbm_we_o, bus.busy_o},
          {25'b0, 7'b1000000});
      chk("reset rsp_dat", bus.rsp_dat_o, 32'h0);
      chk("reset wbm_adr", bus.wbm_adr_o, 32'h0);
      chk("reset wbm_dat/sel", bus.wbm_dat_o | {28'b0, bus.wbm_sel_o}, 32'h0);
      rst = 1'b0;

      // Spurious ack while idle
      for (int i = 0; i < 3; i++) begin
         bus.wbm_ack_i = 1'b1;
         bus.wbm_dat_i = $urandom;
         @(negedge clk);
         chk("idle ack cmd_ready/busy/cyc/rsp_valid",
             {28'b0, bus.cmd_ready_o, bus.busy_o, bus.wbm_cyc_o, bus.rsp_valid_o},
             {28'b0, 4'b1000});
      end
      bus.wbm_ack_i = 1'b0;

      for (int i = 0; i < 4; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      // Reset in the 2nd BUS cycle
      @(negedge clk);
      bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 32'h2000_0000;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      @(negedge clk);
      chk("rst-mid cyc before reset", {31'b0, bus.wbm_cyc_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rst-mid cyc/stb/cmd_ready/rsp_valid/busy",
             {27'b0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.cmd_ready_o, bus.rsp_valid_o, bus.busy_o},
             {27'b0, 5'b00100});
         bus.wbm_ack_i = (i == 0);
         @(negedge clk);
      end
      bus.wbm_ack_i = 1'b0;

`ifdef LA_WBM_TIMEOUT_EN
      run_txn("tmo no-ack", mk(1'b0, 4'hF, 32'h4000_0000, 32'h0, 0, 32'h7777_7777, 1));
      run_txn("tmo ack-at-limit", mk(1'b0, 4'hF, 32'h4000_0004, 32'h0, TB_TMO, 32'h0BAD_CAFE, 0));
      run_txn("tmo late-ack", mk(1'b0, 4'hF, 32'h4000_0008, 32'h0, TB_TMO + 1, 32'h1111_2222, 0));
`endif

      for (int i = 0; i < 40; i++) begin
         int ack_at;
         ack_at = TMO_EN ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
         run_txn($sformatf("rand%0d", i),
                 mk(1'($urandom), 4'($urandom), $urandom, $urandom, ack_at, $urandom,
                    int'($urandom_range(0, 3))));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
